// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide unit controller holding the architectural HI/LO
// registers. Multiplies take 5 busy cycles, divides take 32 restoring
// shift-subtract iterations plus one sign-fix cycle (33 busy cycles).
// Optional feature: define MDU_DIV0_EN to add a div0 output and a 1-cycle
// divide-by-zero path that leaves HI/LO untouched.
module mdu_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        abort,
    output logic        busy,
`ifdef MDU_DIV0_EN
    output logic        div0,
`endif
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    // Counter value during the final busy cycle of each operation.
    localparam logic [5:0] MUL_LAST = 6'd4;
    localparam logic [5:0] DIV_LAST = 6'd32;

    state_t      state_q, state_d;
    logic [5:0]  cnt;
    logic [31:0] opa, opb;     // operands captured at the accepting edge
    logic        sgn;          // captured operation is the signed variant
    logic [31:0] quo, rem;     // divider working registers

    logic        accept, is_mul, is_div, signed_op;
    logic        div_zero, fast_div0, mul_done, div_done;
    logic [31:0] mag_a, dvs, q_fix, r_fix;
    logic [63:0] ext_a, ext_b, prod;
    logic [32:0] shifted, trial;

    assign busy      = (state_q != IDLE);
    assign accept    = (state_q == IDLE) && start && !abort;
    assign is_mul    = (op == OP_MULT) || (op == OP_MULTU);
    assign is_div    = (op == OP_DIV)  || (op == OP_DIVU);
    assign signed_op = (op == OP_MULT) || (op == OP_DIV);
    assign div_zero  = (opb == 32'd0);

`ifdef MDU_DIV0_EN
    assign fast_div0 = (state_q == DIV) && div_zero;
`else
    assign fast_div0 = 1'b0;
`endif

    // Completion edges; abort suppresses any write-back.
    assign mul_done = (state_q == MUL) && (cnt == MUL_LAST) && !abort;
    assign div_done = (state_q == DIV) && (cnt == DIV_LAST) && !abort;

    // Magnitudes used by the divider (0x80000000 maps to 2^31 unsigned).
    assign mag_a = (signed_op && a[31]) ? (32'd0 - a) : a;
    assign dvs   = (sgn && opb[31]) ? (32'd0 - opb) : opb;

    // One restoring step: shift in the next dividend bit, try to subtract.
    assign shifted = {rem, quo[31]};
    assign trial   = shifted - {1'b0, dvs};

    // Sign fix: quotient takes a^b, remainder takes the dividend's sign.
    assign q_fix = (sgn && (opa[31] ^ opb[31])) ? (32'd0 - quo) : quo;
    assign r_fix = (sgn && opa[31]) ? (32'd0 - rem) : rem;

    // The low 64 bits of the product of extended operands are the full
    // signed or unsigned 32x32 product.
    assign ext_a = sgn ? {{32{opa[31]}}, opa} : {32'd0, opa};
    assign ext_b = sgn ? {{32{opb[31]}}, opb} : {32'd0, opb};
    assign prod  = ext_a * ext_b;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            // NOTE: sequential state is always updated with non-blocking
            // assignments so every flop samples pre-edge values.
            state_q <= state_d;
        end
    end

    // Next-state logic; abort wins over start and over completion.
    always_comb begin
        // NOTE: default first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && is_mul) begin
                        state_d = MUL;
                    end else if (start && is_div) begin
                        state_d = DIV;
                    end
                end
                MUL: begin
                    if (cnt == MUL_LAST) state_d = IDLE;
                end
                DIV: begin
                    if ((cnt == DIV_LAST) || fast_div0) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Datapath: counter, operand capture, divider steps and HI/LO write-back.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt  <= 6'd0;
            opa  <= 32'd0;
            opb  <= 32'd0;
            sgn  <= 1'b0;
            quo  <= 32'd0;
            rem  <= 32'd0;
            hi   <= 32'd0;
            lo   <= 32'd0;
`ifdef MDU_DIV0_EN
            div0 <= 1'b0;
`endif
        end else begin
            if (abort || accept || mul_done || div_done || fast_div0) begin
                cnt <= 6'd0;
            end else if (busy) begin
                cnt <= cnt + 6'd1;
            end

            if (accept) begin
                opa <= a;
                opb <= b;
                sgn <= signed_op;
                quo <= mag_a;
                rem <= 32'd0;
            end else if ((state_q == DIV) && (cnt < DIV_LAST) && !abort) begin
                if (!trial[32]) begin
                    rem <= trial[31:0];
                    quo <= {quo[30:0], 1'b1};
                end else begin
                    rem <= shifted[31:0];
                    quo <= {quo[30:0], 1'b0};
                end
            end

            if (accept && (op == OP_MTHI)) hi <= a;
            if (accept && (op == OP_MTLO)) lo <= a;

            if (mul_done) begin
                hi <= prod[63:32];
                lo <= prod[31:0];
            end

            // A zero divisor completes without touching HI/LO.
            if (div_done && !div_zero) begin
                hi <= r_fix;
                lo <= q_fix;
            end

`ifdef MDU_DIV0_EN
            div0 <= fast_div0 && !abort;
`endif
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: self-checking bench for mdu_ctrl. Expected HI/LO values and
// busy durations come from an arithmetic reference model (64-bit products,
// native divide/modulo) plus a few literal vectors.
module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        abort;
    logic        busy;
    logic [31:0] hi, lo;
`ifdef MDU_DIV0_EN
    logic        div0;
    localparam int DIV0_CYC = 1;
`else
    localparam int DIV0_CYC = 33;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Architectural HI/LO as the model believes them to be.
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    always #5 clk = ~clk;

    mdu_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .abort (abort),
        .busy  (busy),
`ifdef MDU_DIV0_EN
        .div0  (div0),
`endif
        .hi    (hi),
        .lo    (lo)
    );

    typedef struct {
        logic [2:0]  o;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] eh;
        logic [31:0] el;
        int          cyc;
    } vec_t;

    // Reference model: resulting HI/LO and number of busy cycles.
    task automatic model_op(input logic [2:0] o, input logic [31:0] x,
                            input logic [31:0] y, output logic [31:0] rh,
                            output logic [31:0] rl, output int cyc);
        logic signed [63:0] sx, sy, sp, sq, sr;
        logic [63:0] up;
        sx  = {{32{x[31]}}, x};
        sy  = {{32{y[31]}}, y};
        rh  = exp_hi;
        rl  = exp_lo;
        cyc = 0;
        case (o)
            3'd0: begin
                sp = sx * sy;
                rh = sp[63:32]; rl = sp[31:0]; cyc = 5;
            end
            3'd1: begin
                up = {32'd0, x} * {32'd0, y};
                rh = up[63:32]; rl = up[31:0]; cyc = 5;
            end
            3'd2: begin
                if (y == 32'd0) begin
                    cyc = DIV0_CYC;
                end else begin
                    sq = sx / sy;
                    sr = sx % sy;
                    rl = sq[31:0]; rh = sr[31:0]; cyc = 33;
                end
            end
            3'd3: begin
                if (y == 32'd0) begin
                    cyc = DIV0_CYC;
                end else begin
                    rl = x / y; rh = x % y; cyc = 33;
                end
            end
            3'd4: rh = x;
            3'd5: rl = x;
            default: ;
        endcase
    endtask

    // Issue one operation at a negedge and count busy cycles until idle.
    // Returns at the first negedge with busy low (bounded).
    task automatic run_op(input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, output int cyc);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; op = 3'($urandom_range(7)); a = $urandom; b = $urandom;
        cyc = 0;
        while (busy === 1'b1 && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; abort = 1'b0; op = 3'd0;
        a = $urandom; b = $urandom;
        repeat (3) @(negedge clk);
        if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++;
        if (hi !== 32'd0) begin n_err++; $display("FAIL reset_hi: got %h want 0", hi); end
        n_cmp++;
        if (lo !== 32'd0) begin n_err++; $display("FAIL reset_lo: got %h want 0", lo); end
        n_cmp++;
`ifdef MDU_DIV0_EN
        if (div0 !== 1'b0) begin n_err++; $display("FAIL reset_div0: got %b want 0", div0); end
        n_cmp++;
`endif
        reset = 1'b1;
        exp_hi = 32'd0; exp_lo = 32'd0;
    endtask

    // MTHI/MTLO and ignored opcodes 6/7: never busy, direct writes.
    task automatic test_mt();
        logic [2:0]  ops [5];
        logic [31:0] xs  [5];
        logic [31:0] rh, rl;
        int mc, cyc;
        ops = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd4};
        xs  = '{32'h12345678, $urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 5; i++) begin
            model_op(ops[i], xs[i], $urandom, rh, rl, mc);
            run_op(ops[i], xs[i], $urandom, cyc);
            if (cyc !== mc) begin n_err++; $display("FAIL mt%0d_busy: got %0d cycles want %0d", i, cyc, mc); end
            n_cmp++;
            if (hi !== rh) begin n_err++; $display("FAIL mt%0d_hi: got %h want %h", i, hi, rh); end
            n_cmp++;
            if (lo !== rl) begin n_err++; $display("FAIL mt%0d_lo: got %h want %h", i, lo, rl); end
            n_cmp++;
            exp_hi = rh; exp_lo = rl;
        end
    endtask

    // Literal vectors, including the signed-overflow divide.
    task automatic test_directed();
        vec_t v [5];
        int cyc;
        v[0] = '{3'd0, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        v[1] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
        v[2] = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33};
        v[3] = '{3'd3, 32'd100,      32'd7,        32'd2,        32'd14,       33};
        v[4] = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 33};
        for (int i = 0; i < 5; i++) begin
            run_op(v[i].o, v[i].x, v[i].y, cyc);
            if (cyc !== v[i].cyc) begin n_err++; $display("FAIL dir%0d_busy: got %0d cycles want %0d", i, cyc, v[i].cyc); end
            n_cmp++;
            if (hi !== v[i].eh) begin n_err++; $display("FAIL dir%0d_hi: got %h want %h", i, hi, v[i].eh); end
            n_cmp++;
            if (lo !== v[i].el) begin n_err++; $display("FAIL dir%0d_lo: got %h want %h", i, lo, v[i].el); end
            n_cmp++;
            exp_hi = v[i].eh; exp_lo = v[i].el;
        end
    endtask

    task automatic test_random();
        logic [2:0]  o;
        logic [31:0] x, y, rh, rl;
        int mc, cyc;
        for (int i = 0; i < 24; i++) begin
            o = 3'($urandom_range(3));
            x = $urandom;
            y = ($urandom_range(3) == 0) ? 32'($urandom_range(15)) : $urandom;
            if (y == 32'd0) y = 32'd9;
            model_op(o, x, y, rh, rl, mc);
            run_op(o, x, y, cyc);
            if (cyc !== mc) begin n_err++; $display("FAIL rnd%0d_busy: op %0d got %0d cycles want %0d", i, o, cyc, mc); end
            n_cmp++;
            if (hi !== rh) begin n_err++; $display("FAIL rnd%0d_hi: op %0d a %h b %h got %h want %h", i, o, x, y, hi, rh); end
            n_cmp++;
            if (lo !== rl) begin n_err++; $display("FAIL rnd%0d_lo: op %0d a %h b %h got %h want %h", i, o, x, y, lo, rl); end
            n_cmp++;
            exp_hi = rh; exp_lo = rl;
        end
    endtask

    // MTLO issued while a divide is busy must be dropped.
    task automatic test_busy_ignore();
        logic [31:0] x, y, rh, rl;
        int mc, cyc;
        x = $urandom; y = $urandom_range(1000, 1);
        model_op(3'd2, x, y, rh, rl, mc);
        start = 1'b1; op = 3'd2; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; op = 3'd5; a = ~exp_lo;
        @(negedge clk);
        start = 1'b0;
        if (lo !== exp_lo) begin n_err++; $display("FAIL busy_mtlo_lo: got %h want %h", lo, exp_lo); end
        n_cmp++;
        cyc = 3;
        while (busy === 1'b1 && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
        if (cyc !== 33) begin n_err++; $display("FAIL busy_ignore_cycles: got %0d want 33", cyc); end
        n_cmp++;
        if (hi !== rh || lo !== rl) begin
            n_err++; $display("FAIL busy_ignore_result: got %h_%h want %h_%h", hi, lo, rh, rl);
        end
        n_cmp++;
        exp_hi = rh; exp_lo = rl;
    endtask

    task automatic test_abort();
        // Abort at iteration 10 of a divide.
        start = 1'b1; op = 3'd2; a = $urandom; b = $urandom_range(50, 1);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        if (busy !== 1'b0) begin n_err++; $display("FAIL abort_div_busy: got %b want 0", busy); end
        n_cmp++;
        if (hi !== exp_hi || lo !== exp_lo) begin
            n_err++; $display("FAIL abort_div_hilo: got %h_%h want %h_%h", hi, lo, exp_hi, exp_lo);
        end
        n_cmp++;
        // Abort coinciding with the multiply completion edge.
        start = 1'b1; op = 3'd1; a = $urandom; b = $urandom;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        if (busy !== 1'b0) begin n_err++; $display("FAIL abort_mul_busy: got %b want 0", busy); end
        n_cmp++;
        if (hi !== exp_hi || lo !== exp_lo) begin
            n_err++; $display("FAIL abort_mul_hilo: got %h_%h want %h_%h", hi, lo, exp_hi, exp_lo);
        end
        n_cmp++;
        // Abort beats a simultaneous MTHI start.
        start = 1'b1; op = 3'd4; a = ~exp_hi; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        if (hi !== exp_hi || busy !== 1'b0) begin
            n_err++; $display("FAIL abort_start: got hi %h busy %b want hi %h busy 0", hi, busy, exp_hi);
        end
        n_cmp++;
    endtask

    // A start in the first idle cycle after completion is taken at once.
    task automatic test_back_to_back();
        logic [31:0] x, y, rh, rl;
        int mc, cyc;
        x = $urandom; y = $urandom;
        model_op(3'd0, x, y, rh, rl, mc);
        run_op(3'd0, x, y, cyc);
        if (cyc !== 5 || hi !== rh || lo !== rl) begin
            n_err++; $display("FAIL b2b_first: got %0d %h_%h want 5 %h_%h", cyc, hi, lo, rh, rl);
        end
        n_cmp++;
        exp_hi = rh; exp_lo = rl;
        x = $urandom; y = $urandom_range(100000, 1);
        model_op(3'd3, x, y, rh, rl, mc);
        start = 1'b1; op = 3'd3; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
        if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_accept: busy got %b want 1", busy); end
        n_cmp++;
        cyc = 0;
        while (busy === 1'b1 && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
        if (cyc !== 33 || hi !== rh || lo !== rl) begin
            n_err++; $display("FAIL b2b_second: got %0d %h_%h want 33 %h_%h", cyc, hi, lo, rh, rl);
        end
        n_cmp++;
        exp_hi = rh; exp_lo = rl;
    endtask

    task automatic test_div0();
        logic [31:0] rh, rl;
        int mc, cyc;
        model_op(3'd3, 32'd5, 32'd0, rh, rl, mc);
        run_op(3'd3, 32'd5, 32'd0, cyc);
        if (cyc !== mc) begin n_err++; $display("FAIL div0_busy: got %0d cycles want %0d", cyc, mc); end
        n_cmp++;
        if (hi !== rh || lo !== rl) begin
            n_err++; $display("FAIL div0_hilo: got %h_%h want %h_%h", hi, lo, rh, rl);
        end
        n_cmp++;
`ifdef MDU_DIV0_EN
        if (div0 !== 1'b1) begin n_err++; $display("FAIL div0_pulse: got %b want 1", div0); end
        n_cmp++;
        @(negedge clk);
        if (div0 !== 1'b0) begin n_err++; $display("FAIL div0_clear: got %b want 0", div0); end
        n_cmp++;
`endif
    endtask

    // Asynchronous reset during a multiply, then accept on the first edge.
    task automatic test_reset_mid();
        logic [31:0] v;
        start = 1'b1; op = 3'd0; a = $urandom; b = $urandom;
        @(negedge clk);
        start = 1'b0;
        #2 reset = 1'b0;
        #1;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            n_err++; $display("FAIL reset_mid: got busy %b %h_%h want 0 0_0", busy, hi, lo);
        end
        n_cmp++;
        exp_hi = 32'd0; exp_lo = 32'd0;
        @(negedge clk);
        v = $urandom;
        reset = 1'b1;
        start = 1'b1; op = 3'd4; a = v;
        @(negedge clk);
        start = 1'b0;
        if (hi !== v || lo !== 32'd0 || busy !== 1'b0) begin
            n_err++; $display("FAIL reset_release: got hi %h lo %h busy %b want %h 0 0", hi, lo, busy, v);
        end
        n_cmp++;
        exp_hi = v;
    endtask

    initial begin
        test_reset();
        @(negedge clk);
        test_mt();
        test_directed();
        test_random();
        test_busy_ignore();
        test_abort();
        test_back_to_back();
        test_div0();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
